// File: rtl/alu_muldiv.sv
// Multi-cycle execute-stage ALU: RV32I/RV64I ALU/branch ops plus the M extension.
// Base ops finish in one cycle; MUL* and DIV/REM use radix-2 sequencers unless FAST_MUL is set.
module alu_muldiv #(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            branch_op,
    input  logic [5:0]      alu_control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            branch,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state;
    logic [SHW-1:0]  cnt;
    logic            op_hi;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] p_hi;
    logic [XLEN-1:0] p_lo;

    logic            is_mul;
    logic            is_div;
    logic            sgn_a;
    logic            sgn_b;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] div_special;
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0] fast_res;

    logic            is_cmp;
    logic            lt_s;
    logic            lt_u;
    logic            eq;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;

    logic [XLEN:0]     mac_sum;
    logic [2*XLEN-1:0] prod_n;
    logic [XLEN:0]     trial;
    logic              ge;
    logic [XLEN-1:0]   rem_n;
    logic [XLEN-1:0]   quo_n;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;

    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] prod,
                                                 input logic neg, input logic hi);
        logic [2*XLEN-1:0] fixed;
        fixed = neg ? -prod : prod;
        return hi ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_MUL) || (state == S_DIV);

    // Operand signedness: MULHSU treats only A as signed, MULHU/DIVU/REMU neither.
    always_comb begin
        is_mul   = (alu_control[5:2] == 4'b1000);
        is_div   = (alu_control[5:2] == 4'b1001);
        sgn_a    = is_mul ? (alu_control[1:0] != 2'b11) : ~alu_control[0];
        sgn_b    = is_mul ? ~alu_control[1] : ~alu_control[0];
        a_neg    = sgn_a & operand_a[XLEN-1];
        b_neg    = sgn_b & operand_b[XLEN-1];
        mag_a    = a_neg ? -operand_a : operand_a;
        mag_b    = b_neg ? -operand_b : operand_b;
        div_zero = (operand_b == '0);
        div_ovf  = ~alu_control[0] && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
        if (div_zero) begin
            div_special = alu_control[1] ? operand_a : '1;
        end else begin
            div_special = alu_control[1] ? '0 : operand_a;
        end
        fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        fast_res  = mul_pick(fast_prod, a_neg ^ b_neg, alu_control[1:0] != 2'b00);
    end

    always_comb begin
        shamt    = operand_b[SHW-1:0];
        lt_s     = ($signed(operand_a) < $signed(operand_b));
        lt_u     = (operand_a < operand_b);
        eq       = (operand_a == operand_b);
        base_res = '0;
        is_cmp   = 1'b0;
        case (alu_control)
            6'b000000:            base_res = operand_a + operand_b;
            6'b001000:            base_res = operand_a - operand_b;
            6'b000010:            begin base_res = {{(XLEN-1){1'b0}}, lt_s};  is_cmp = 1'b1; end
            6'b000011, 6'b010110: begin base_res = {{(XLEN-1){1'b0}}, lt_u};  is_cmp = 1'b1; end
            6'b010101:            begin base_res = {{(XLEN-1){1'b0}}, ~lt_s}; is_cmp = 1'b1; end
            6'b010111:            begin base_res = {{(XLEN-1){1'b0}}, ~lt_u}; is_cmp = 1'b1; end
            6'b010000:            begin base_res = {{(XLEN-1){1'b0}}, eq};    is_cmp = 1'b1; end
            6'b010001:            begin base_res = {{(XLEN-1){1'b0}}, ~eq};   is_cmp = 1'b1; end
            6'b000110:            base_res = operand_a | operand_b;
            6'b000100:            base_res = operand_a ^ operand_b;
            6'b000111:            base_res = operand_a & operand_b;
            6'b000001:            base_res = operand_a << shamt;
            6'b000101:            base_res = operand_a >> shamt;
            6'b001101:            base_res = $signed(operand_a) >>> shamt;
            6'b011111, 6'b111111: base_res = operand_a;
            default:              base_res = '0;
        endcase
    end

    // One shift-add step ({p_hi,p_lo} shifts right) and one restoring-divide step
    // (dividend shifts out of p_lo into the partial remainder p_hi).
    always_comb begin
        mac_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
        prod_n  = {mac_sum, p_lo[XLEN-1:1]};
        trial   = {p_hi, p_lo[XLEN-1]};
        ge      = (trial >= {1'b0, mcand});
        rem_n   = ge ? (trial[XLEN-1:0] - mcand) : trial[XLEN-1:0];
        quo_n   = {p_lo[XLEN-2:0], ge};
        q_fix   = neg_q ? -quo_n : quo_n;
        r_fix   = neg_r ? -rem_n : rem_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            alu_result <= '0;
            branch     <= 1'b0;
            cnt        <= '0;
            op_hi      <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            mcand      <= '0;
            p_hi       <= '0;
            p_lo       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        cnt    <= '0;
                        p_hi   <= '0;
                        branch <= 1'b0;
                        if (is_mul) begin
                            op_hi <= (alu_control[1:0] != 2'b00);
                            neg_q <= a_neg ^ b_neg;
                            mcand <= mag_a;
                            p_lo  <= mag_b;
                            if (FAST_MUL != 0) begin
                                alu_result <= fast_res;
                                state      <= S_DONE;
                            end else begin
                                state <= S_MUL;
                            end
                        end else if (is_div) begin
                            op_hi <= alu_control[1];
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            mcand <= mag_b;
                            p_lo  <= mag_a;
                            if (div_zero || div_ovf) begin
                                alu_result <= div_special;
                                state      <= S_DONE;
                            end else begin
                                state <= S_DIV;
                            end
                        end else begin
                            alu_result <= base_res;
                            branch     <= branch_op & is_cmp & base_res[0];
                            state      <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    p_hi <= prod_n[2*XLEN-1:XLEN];
                    p_lo <= prod_n[XLEN-1:0];
                    cnt  <= cnt + 1'b1;
                    if (cnt == SHW'(XLEN-1)) begin
                        alu_result <= mul_pick(prod_n, neg_q, op_hi);
                        state      <= S_DONE;
                    end
                end
                S_DIV: begin
                    p_hi <= rem_n;
                    p_lo <= quo_n;
                    cnt  <= cnt + 1'b1;
                    if (cnt == SHW'(XLEN-1)) begin
                        alu_result <= op_hi ? r_fix : q_fix;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU.
- Executes the full RV32I/RV64I ALU and branch-compare op set, plus the RISC-V M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), at configurable XLEN.
- Valid/ready handshakes on both sides, so the core stalls on the iterative mul/div sequencers while simple ops complete in one cycle.
- Sits in the execute stage between the operand muxes and writeback/PC select.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- FAST_MUL, 0, 1 selects a single-cycle combinational multiplier; 0 selects the iterative shift-add sequencer.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- branch_op  in  1  operation is a conditional branch.
- alu_control  in  6  operation code.
- operand_a  in  XLEN  source A.
- operand_b  in  XLEN  source B.
- out_valid  out  1  result/branch valid.
- out_ready  in  1  consumer accepts the result.
- alu_result  out  XLEN  result.
- branch  out  1  branch taken; meaningful only when out_valid.
- busy  out  1  mul/div sequencer active.

Behaviour:
- Reset values: state=IDLE, out_valid=0, alu_result=0, branch=0, busy=0, in_ready=1.
- Accept rule: an operation is accepted when in_valid && in_ready. Operands, alu_control and branch_op are latched on acceptance. Inputs are ignored at all other times.
- Base op encodings:
  - 000000 ADD; 001000 SUB; 000010 SLT (signed); 000011 and 010110 SLTU/BLTU.
  - 010101 BGE (signed ≥); 010111 BGEU; 000110 OR; 000100 XOR; 000111 AND.
  - 000001 SLL; 000101 SRL; 001101 SRA; 010000 EQ; 010001 NE; 011111 and 111111 pass operand_a.
  - Any other code returns 0.
- M-extension encodings: 100000 MUL, 100001 MULH, 100010 MULHSU, 100011 MULHU, 100100 DIV, 100101 DIVU, 100110 REM, 100111 REMU.
- Width rules:
  - Compare results are zero-extended 0/1.
  - Shift amount is operand_b[log2(XLEN)-1:0]; upper bits are ignored.
  - Add/sub wrap modulo 2^XLEN.
  - MUL returns the low XLEN bits of the 2*XLEN product. MULH*/MULHU return the high XLEN bits, with signedness per the RISC-V spec (MULHSU: A signed, B unsigned).
- branch is registered with the result:
  - 1 iff branch_op=1 and the op is one of EQ, NE, SLT, BGE, SLTU/BLTU, BGEU and its condition is true.
  - Otherwise 0. Mul/div ops always give branch=0.
- States:
  - IDLE: on accept, base op → DONE with result registered (latency 1). MUL* with FAST_MUL=1 → DONE (latency 1). MUL* with FAST_MUL=0 → MUL. DIV/REM special cases → DONE (latency 1). Other DIV/REM → DIV.
  - MUL: radix-2 shift-add on magnitudes, XLEN iterations, sign fixup on the final cycle, then → DONE. Latency is XLEN+1 cycles from accept to out_valid.
  - DIV: restoring division on magnitudes, XLEN iterations, sign fixup (quotient sign = sA^sB, remainder sign = sA), then → DONE. Latency is XLEN+1.
  - DONE: out_valid=1, result held stable. out_ready=1 → IDLE; otherwise stay. in_ready=0 in DONE.
- busy=1 exactly in MUL or DIV.
- Divide special cases:
  - Divide by zero: quotient = all ones, remainder = operand_a (signed and unsigned).
  - Signed overflow (A = -2^(XLEN-1), B = -1): quotient = A, remainder = 0.
- Back-to-back: a new op cannot be accepted in the same cycle DONE retires, so maximum base-op throughput is 1 per 2 cycles. This is fixed.
- Reset asserted mid-operation aborts the sequencer. Next cycle: IDLE, out_valid=0, result cleared, no result emitted.
- Operand changes while not in IDLE have no effect.

Test Plan:
- XLEN=32, ADD 0xFFFFFFFF+1 → out_valid one cycle after accept, result 0, branch 0. SRA 0x80000000 by 0x24 (shamt 4) → 0xF8000000.
- branch_op=1, BLT: A=0xFFFFFFFF, B=1 → result 1, branch 1. Same operands with BLTU (010110) → result 0, branch 0.
- MUL, FAST_MUL=0: A=-3, B=7 → busy for 32 cycles, out_valid at cycle 33, result 0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 after 1 cycle; REM of same → 0. DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7. REM -7/2 → 0xFFFFFFFF after 33 cycles.
- Hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0, new in_valid ignored. Raise out_ready → IDLE next cycle.
- Assert reset at iteration 10 of a DIV → next cycle IDLE, out_valid=0, busy=0, alu_result=0. Re-run with XLEN=64: DIVU 2^64-1 / 3 → 0x5555555555555555 at cycle 65.
